// File: rtl/rx_serial_param.sv
// Parametrised async serial receiver: 2-FF sync, mid-bit sampling, parity/framing/overrun flags.
// Latency: pronto one cycle after the final stop sample; back-to-back start bits are caught.
module rx_serial_param #(
  parameter int DIV       = 434,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  input  logic       recebido,
  output logic       pronto,
  output logic [7:0] dados_ascii,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_parada,
  output logic       erro_sobreposicao,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    START    = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    ARMAZENA = 4'd5
  } state_t;

  localparam logic [15:0] HALF_LIM = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL_LIM = 16'(DIV - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  SB_LAST  = 4'(STOP_BITS - 1);
  localparam logic        ODD_PAR  = (PARITY == 2);

  state_t                 state, state_nx;
  logic                   rx_s1, rx_s2, rx_s3;
  logic [15:0]            cnt;
  logic [3:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err, frm_err;
  logic                   fall, tick;

  assign fall      = rx_s3 & ~rx_s2;
  assign tick      = (state == START) ? (cnt == HALF_LIM) : (cnt == FULL_LIM);
  assign db_estado = state;

  always_comb begin
    state_nx = state;
    case (state)
      OCIOSO:   if (fall) state_nx = START;
      START:    if (tick) state_nx = rx_s2 ? OCIOSO : DADOS;
      DADOS:    if (tick && bit_cnt == DB_LAST) state_nx = (PARITY != 0) ? PARIDADE : PARADA;
      PARIDADE: if (tick) state_nx = PARADA;
      PARADA:   if (tick && bit_cnt == SB_LAST) state_nx = ARMAZENA;
      ARMAZENA: state_nx = OCIOSO;
      default:  state_nx = OCIOSO;
    endcase
  end

  // Synchroniser resets high so release never looks like a start edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
      state <= OCIOSO;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      if (state_nx != state || state == OCIOSO) begin
        cnt     <= '0;
        bit_cnt <= '0;
      end else if (tick) begin
        cnt     <= '0;
        bit_cnt <= bit_cnt + 4'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      if (state == OCIOSO && fall) begin
        par_err <= 1'b0;
        frm_err <= 1'b0;
      end
      if (state == DADOS && tick)
        shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
      if (state == PARIDADE && tick)
        par_err <= ^shreg ^ rx_s2 ^ ODD_PAR;
      if (state == PARADA && tick && !rx_s2)
        frm_err <= 1'b1;
    end
  end

  // A store and an acknowledge in the same cycle: the new byte wins, no overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pronto            <= 1'b0;
      dados_ascii       <= '0;
      tem_dado          <= 1'b0;
      erro_paridade     <= 1'b0;
      erro_parada       <= 1'b0;
      erro_sobreposicao <= 1'b0;
    end else begin
      pronto <= (state == ARMAZENA);
      if (state == ARMAZENA) begin
        dados_ascii   <= 8'(shreg);
        erro_paridade <= (PARITY != 0) && par_err;
        erro_parada   <= frm_err;
        tem_dado      <= 1'b1;
        if (tem_dado && !recebido)
          erro_sobreposicao <= 1'b1;
      end else if (recebido) begin
        tem_dado          <= 1'b0;
        erro_sobreposicao <= 1'b0;
      end
    end
  end

endmodule
